// File: rtl/sr_flag_pkg.sv
// Shared types for the sticky-flag reader.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: reader FSM state encoding and the upper bound on flag count.
package sr_flag_pkg;

   typedef enum logic {
      SCAN  = 1'b0,
      OFFER = 1'b1
   } sr_rd_state_t;

   localparam int N_MAX = 64;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: req[N] request vector, ptr[IW] start index; gnt_valid any request, gnt_idx chosen index.
module rr_pick #(
   parameter  int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   // Doubling the request vector lets a plain part-select rotate it so
   // that bit 0 of rot corresponds to request[ptr].
   logic [2*N-1:0] req2;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;

   assign req2 = {req, req};
   assign rot  = req2[ptr +: N];

   always_comb begin
      gnt_valid = |req;
      off       = '0;
      // Descending loop so the lowest set bit of rot wins.
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off = IW'(j);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW+1)'(N)) begin
         sum = sum - (IW+1)'(N);
      end
      gnt_idx = sum[IW-1:0];
   end

endmodule

// File: rtl/sr_flag_reader.sv
// Sticky event flags scanned round-robin and reported one index at a time; report acceptance clears the flag.
// Latency: set at edge E -> pending after E -> evt_valid after E+1; one idle SCAN cycle between reports.
// Backpressure: evt_idx/evt_valid hold while evt_ready=0; further sets to the offered flag raise evt_ovf.
// Ports: clk, clr (sync reset), en/set[N] producer side, flush (sync clear), evt_valid/evt_ready/evt_idx/evt_ovf
//        report handshake, pending[N] flag vector, busy (any flag set or offer outstanding).
module sr_flag_reader
   import sr_flag_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [N-1:0]  en,
   input  logic [N-1:0]  set,
   input  logic          flush,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [IW-1:0] evt_idx,
   output logic          evt_ovf,
   output logic [N-1:0]  pending,
   output logic          busy
);

   sr_rd_state_t  state_q, state_d;
   logic [N-1:0]  flag_q, flag_d;
   logic [N-1:0]  ovf_q, ovf_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          evt_valid_q, evt_valid_d;
   logic [IW-1:0] evt_idx_q, evt_idx_d;
   logic          evt_ovf_q, evt_ovf_d;

   logic          hs;
   logic [N-1:0]  set_eff;
   logic [N-1:0]  hs_mask;
   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;

   rr_pick #(.N(N)) u_pick (
      .req       (flag_q),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Flag and overflow bookkeeping.
   always_comb begin
      hs      = evt_valid_q & evt_ready;
      set_eff = set & en;
      hs_mask = hs ? (N'(1) << evt_idx_q) : '0;

      // A set on the handshake edge of the same flag keeps it pending but
      // starts a fresh report with no loss recorded.
      flag_d = (flag_q & ~hs_mask) | set_eff;
      ovf_d  = (ovf_q | (set_eff & flag_q)) & ~hs_mask;

      if (flush) begin
         flag_d = '0;
         ovf_d  = '0;
      end
   end

   // Reader FSM: next state and output registers.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      evt_valid_d = evt_valid_q;
      evt_idx_d   = evt_idx_q;
      evt_ovf_d   = evt_ovf_q;

      if (flush) begin
         state_d     = SCAN;
         evt_valid_d = 1'b0;
         evt_ovf_d   = 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (gnt_valid) begin
                  state_d     = OFFER;
                  evt_valid_d = 1'b1;
                  evt_idx_d   = gnt_idx;
                  evt_ovf_d   = ovf_d[gnt_idx];
               end
            end
            OFFER: begin
               if (hs) begin
                  state_d     = SCAN;
                  evt_valid_d = 1'b0;
                  evt_ovf_d   = 1'b0;
                  ptr_d       = (evt_idx_q == IW'(N - 1)) ? '0 : evt_idx_q + 1'b1;
               end else begin
                  // Track losses that happen while the consumer stalls.
                  evt_ovf_d = ovf_d[evt_idx_q];
               end
            end
            default: begin
               state_d     = SCAN;
               evt_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= SCAN;
         flag_q      <= '0;
         ovf_q       <= '0;
         ptr_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_idx_q   <= '0;
         evt_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flag_q      <= flag_d;
         ovf_q       <= ovf_d;
         ptr_q       <= ptr_d;
         evt_valid_q <= evt_valid_d;
         evt_idx_q   <= evt_idx_d;
         evt_ovf_q   <= evt_ovf_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_idx   = evt_idx_q;
   assign evt_ovf   = evt_ovf_q;
   assign pending   = flag_q;
   assign busy      = (|flag_q) | evt_valid_q;

endmodule

// File: tb/tb_sr_flag_reader.sv
// Bench for sr_flag_reader: directed scenarios followed by random traffic, all checked against a flag-set model.
// Latency: n/a. Backpressure: evt_ready driven directly by the stimulus.
// Ports: none (top-level bench).
module tb_sr_flag_reader;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          clr, flush, evt_ready;
   logic [N-1:0]  en, set;
   logic          evt_valid, evt_ovf, busy;
   logic [IW-1:0] evt_idx;
   logic [N-1:0]  pending;

   always #5 clk = ~clk;

   sr_flag_reader #(.N(N)) dut (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .set       (set),
      .flush     (flush),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_idx   (evt_idx),
      .evt_ovf   (evt_ovf),
      .pending   (pending),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a set of pending flags, loss markers, a scan start
   // point and at most one outstanding offer.
   bit m_flag[N];
   bit m_ovf[N];
   int m_ptr;
   bit m_off;
   int m_idx;
   int acc_log[$];   // indices the DUT presented at accepted handshakes

   task automatic step(input logic [N-1:0] s, input logic [N-1:0] e,
                       input bit fl, input bit cl, input bit rdy);
      bit nf[N];
      bit no[N];
      bit hs;
      int found;
      logic [N-1:0] exp_pend;
      bit any;

      set = s; en = e; flush = fl; clr = cl; evt_ready = rdy;
      if (evt_valid === 1'b1 && rdy && !cl && !fl) acc_log.push_back(int'(evt_idx));
      @(posedge clk);

      hs = m_off && rdy && !cl && !fl;
      for (int i = 0; i < N; i++) begin
         if (cl || fl) begin
            nf[i] = 0;
            no[i] = 0;
         end else begin
            if (s[i] && e[i])              nf[i] = 1;
            else if (hs && m_idx == i)     nf[i] = 0;
            else                           nf[i] = m_flag[i];
            if (hs && m_idx == i)               no[i] = 0;
            else if (s[i] && e[i] && m_flag[i]) no[i] = 1;
            else                                no[i] = m_ovf[i];
         end
      end
      if (cl) begin
         m_off = 0; m_idx = 0; m_ptr = 0;
      end else if (fl) begin
         m_off = 0;
      end else if (m_off) begin
         if (hs) begin
            m_off = 0;
            m_ptr = (m_idx + 1) % N;
         end
      end else begin
         found = -1;
         for (int k = 0; k < N; k++) begin
            if (found < 0 && m_flag[(m_ptr + k) % N]) found = (m_ptr + k) % N;
         end
         if (found >= 0) begin
            m_off = 1;
            m_idx = found;
         end
      end
      m_flag = nf;
      m_ovf  = no;

      #1;
      any = 0;
      for (int i = 0; i < N; i++) begin
         exp_pend[i] = m_flag[i];
         if (m_flag[i]) any = 1;
      end
      chk("evt_valid", evt_valid, m_off);
      chk("pending", pending, exp_pend);
      chk("busy", busy, any || m_off);
      if (m_off) begin
         chk("evt_idx", evt_idx, m_idx);
         chk("evt_ovf", evt_ovf, m_ovf[m_idx]);
      end
      if (cl) begin
         chk("rst_idx", evt_idx, 0);
         chk("rst_ovf", evt_ovf, 0);
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int c = 0; c < n; c++) step('0, '1, 0, 0, rdy);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_flag[i] = 0;
         m_ovf[i]  = 0;
      end
      m_ptr = 0; m_off = 0; m_idx = 0;

      // Reset and idle.
      step('0, '1, 0, 1, 0);
      step('0, '1, 0, 1, 0);
      idle(10, 0);

      // Single event at index 4; reported two edges after the pulse.
      step(8'h10, 8'hFF, 0, 0, 1);
      chk("single_not_yet", evt_valid, 0);
      step('0, '1, 0, 0, 1);
      chk("single_valid", evt_valid, 1);
      chk("single_idx", evt_idx, 4);
      idle(4, 1);
      chk("single_log", acc_log.pop_back(), 4);

      // Next search starts at 5: flags 0 and 5 report as 5 then 0.
      acc_log.delete();
      step(8'h21, 8'hFF, 0, 0, 1);
      idle(8, 1);
      chk("after4_cnt", acc_log.size(), 2);
      chk("after4_first", acc_log[0], 5);
      chk("after4_second", acc_log[1], 0);

      // Move scan start to 6, then wrap 6,7,0,1.
      step(8'h20, 8'hFF, 0, 0, 1);
      idle(5, 1);
      acc_log.delete();
      step(8'hC3, 8'hFF, 0, 0, 1);
      idle(12, 1);
      chk("wrap_cnt", acc_log.size(), 4);
      chk("wrap_0", acc_log[0], 6);
      chk("wrap_1", acc_log[1], 7);
      chk("wrap_2", acc_log[2], 0);
      chk("wrap_3", acc_log[3], 1);

      // Backpressure with a lost set of flag 2.
      step(8'h04, 8'hFF, 0, 0, 0);
      idle(5, 0);
      chk("bp_idx", evt_idx, 2);
      chk("bp_ovf0", evt_ovf, 0);
      step(8'h04, 8'hFF, 0, 0, 0);
      chk("bp_ovf1", evt_ovf, 1);
      idle(3, 0);
      chk("bp_ovf_hold", evt_ovf, 1);
      step('0, '1, 0, 0, 1);
      chk("bp_pend_clr", pending[2], 0);
      idle(3, 1);

      // Set colliding with the handshake of the same index.
      acc_log.delete();
      step(8'h08, 8'hFF, 0, 0, 0);
      idle(3, 0);
      step(8'h08, 8'hFF, 0, 0, 1);
      chk("coll_pend", pending[3], 1);
      step('0, '1, 0, 0, 0);
      chk("coll_reoffer_ovf", evt_ovf, 0);
      idle(4, 1);
      chk("coll_cnt", acc_log.size(), 2);
      // Same collision with the enable off: the pulse is dropped.
      step(8'h08, 8'hFF, 0, 0, 0);
      idle(3, 0);
      step(8'h08, 8'hF7, 0, 0, 1);
      chk("coll_en_off", pending[3], 0);
      idle(3, 1);

      // Flush mid-offer of index 5 with others pending.
      acc_log.delete();
      step(8'h61, 8'hFF, 0, 0, 0);
      idle(2, 0);
      chk("fl_idx", evt_idx, 5);
      step('0, '1, 1, 0, 1);
      chk("fl_valid", evt_valid, 0);
      chk("fl_pend", pending, 0);
      idle(3, 1);
      chk("fl_no_hs", acc_log.size(), 0);

      // Same with clr; scan start returns to 0.
      step(8'h61, 8'hFF, 0, 0, 0);
      idle(2, 0);
      step('0, '1, 0, 1, 1);
      chk("clr_valid", evt_valid, 0);
      chk("clr_pend", pending, 0);
      chk("clr_no_hs", acc_log.size(), 0);
      step(8'h82, 8'hFF, 0, 0, 0);
      step('0, '1, 0, 0, 0);
      chk("clr_ptr0", evt_idx, 1);
      idle(6, 1);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] s, e;
         s = N'($urandom & $urandom & $urandom);
         e = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         step(s, e, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0,
              $urandom_range(0, 2) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
